// File: rtl/fp_acc_pkg.sv
// Shared types, constants and the ReLU helper for the multi-channel FP accumulator.
package fp_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_e;

    localparam int unsigned FP_W        = 32;
    localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
    localparam int unsigned FP_SIGN_BIT = 31;

    // A set sign bit (including -0.0, -Inf and negative NaN) collapses to +0.0.
    function automatic logic [31:0] relu(input logic [31:0] x, input logic en);
        return (en && x[FP_SIGN_BIT]) ? FP_ZERO : x;
    endfunction

endpackage

// File: rtl/FP_Adder.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even.
module FP_Adder (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o
);

    logic        a_nan, b_nan, a_inf, b_inf;
    logic [31:0] big, sml;
    logic [7:0]  e_big, e_sml, diff;
    logic [4:0]  shamt, lz, shl;
    logic [26:0] m_big, m_sml, norm;
    logic [58:0] wide;
    logic [27:0] sum;
    logic [9:0]  exp_n, lim;
    logic        rnd_up;
    logic [24:0] mant;

    always_comb begin
        a_nan = (a_i[30:23] == 8'hFF) && (a_i[22:0] != '0);
        b_nan = (b_i[30:23] == 8'hFF) && (b_i[22:0] != '0);
        a_inf = (a_i[30:23] == 8'hFF) && (a_i[22:0] == '0);
        b_inf = (b_i[30:23] == 8'hFF) && (b_i[22:0] == '0);

        if (a_i[30:0] >= b_i[30:0]) begin
            big = a_i;
            sml = b_i;
        end else begin
            big = b_i;
            sml = a_i;
        end

        e_big = (big[30:23] == '0) ? 8'd1 : big[30:23];
        e_sml = (sml[30:23] == '0) ? 8'd1 : sml[30:23];
        m_big = {big[30:23] != '0, big[22:0], 3'b000};
        diff  = e_big - e_sml;
        // Beyond 31 the smaller operand already lies entirely in the sticky field.
        shamt = (diff > 8'd31) ? 5'd31 : diff[4:0];
        wide  = {sml[30:23] != '0, sml[22:0], 35'b0} >> shamt;
        m_sml = {wide[58:33], wide[32] | (|wide[31:0])};

        if (big[31] ^ sml[31]) sum = {1'b0, m_big} - {1'b0, m_sml};
        else                   sum = {1'b0, m_big} + {1'b0, m_sml};

        exp_n = {2'b00, e_big};
        lz    = 5'd27;
        lim   = '0;
        shl   = '0;
        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_n = exp_n + 10'd1;
        end else begin
            for (int unsigned i = 0; i < 27; i++) begin
                if (sum[i]) lz = 5'(26 - i);
            end
            lim   = exp_n - 10'd1;
            shl   = ({5'b0, lz} < lim) ? lz : lim[4:0];
            norm  = sum[26:0] << shl;
            exp_n = exp_n - {5'b0, shl};
            if (!norm[26]) exp_n = '0;
        end

        rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant   = {1'b0, norm[26:3]} + 25'(rnd_up);
        if (mant[24]) begin
            mant  = mant >> 1;
            exp_n = exp_n + 10'd1;
        end else if (exp_n == '0 && mant[23]) begin
            exp_n = 10'd1;
        end

        if (exp_n >= 10'd255) sum_o = {big[31], 8'hFF, 23'b0};
        else                  sum_o = {big[31], exp_n[7:0], mant[22:0]};

        if (sum == '0) sum_o = {big[31] & sml[31], 31'b0};

        if (a_nan)                                  sum_o = a_i | 32'h0040_0000;
        else if (b_nan)                             sum_o = b_i | 32'h0040_0000;
        else if (a_inf && b_inf && (a_i[31] != b_i[31])) sum_o = 32'h7FC0_0000;
        else if (a_inf)                             sum_o = a_i;
        else if (b_inf)                             sum_o = b_i;
    end

endmodule

// File: rtl/fp_acc_lane.sv
// One accumulator channel: bias/sum load mux, FP adder, and ReLU result register.
module fp_acc_lane
    import fp_acc_pkg::*;
#(
    parameter bit RELU_EN = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_bias_i,
    input  logic            accumulate_i,
    input  logic            capture_i,
    input  logic [FP_W-1:0] bias_i,
    input  logic [FP_W-1:0] data_i,
    output logic [FP_W-1:0] result_o
);

    logic [FP_W-1:0] acc_q, acc_d;
    logic [FP_W-1:0] res_q, res_d;
    logic [FP_W-1:0] sum;

    FP_Adder u_add (
        .a_i   (acc_q),
        .b_i   (data_i),
        .sum_o (sum)
    );

    always_comb begin
        acc_d = acc_q;
        res_d = res_q;
        if (load_bias_i)       acc_d = bias_i;
        else if (accumulate_i) acc_d = sum;
        if (capture_i)         res_d = relu(sum, RELU_EN);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            res_q <= '0;
        end else begin
            acc_q <= acc_d;
            res_q <= res_d;
        end
    end

    assign result_o = res_q;

endmodule

// File: rtl/fp_multi_ch_accumulator.sv
// Multi-channel FP accumulator: bias preload, Acc_Len product beats, optional ReLU,
// one packed result word per pixel under valid/ready.
module fp_multi_ch_accumulator
    import fp_acc_pkg::*;
#(
    parameter int Data_Width = 32,
    parameter int Num_Ch     = 6,
    parameter int Acc_Len    = 25,
    parameter int Relu_En    = 1,
    parameter int Cnt_Width  = $clog2(Acc_Len + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [Num_Ch*Data_Width-1:0] bias_in,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [Num_Ch*Data_Width-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [Num_Ch*Data_Width-1:0] out_data,
    output logic                         busy
);

    localparam logic [Cnt_Width-1:0] LAST_BEAT = Cnt_Width'(Acc_Len - 1);

    state_e               state_q, state_d;
    logic [Cnt_Width-1:0] count_q, count_d;
    logic                 load_bias, accumulate, capture;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        load_bias  = 1'b0;
        accumulate = 1'b0;
        capture    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_bias = 1'b1;
                    count_d   = '0;
                    state_d   = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    accumulate = 1'b1;
                    count_d    = count_q + Cnt_Width'(1);
                    if (count_q == LAST_BEAT) begin
                        capture = 1'b1;
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                // Handshake with start reloads straight into ACCUM for back-to-back pixels.
                if (out_ready) begin
                    if (start) begin
                        load_bias = 1'b1;
                        count_d   = '0;
                        state_d   = ACCUM;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);

    for (genvar k = 0; k < Num_Ch; k++) begin : g_lane
        fp_acc_lane #(
            .RELU_EN (Relu_En != 0)
        ) u_lane (
            .clk_i        (clk),
            .rst_i        (reset),
            .load_bias_i  (load_bias),
            .accumulate_i (accumulate),
            .capture_i    (capture),
            .bias_i       (bias_in[k*Data_Width +: Data_Width]),
            .data_i       (in_data[k*Data_Width +: Data_Width]),
            .result_o     (out_data[k*Data_Width +: Data_Width])
        );
    end

endmodule

// File: tb/tb_fp_multi_ch_accumulator.sv
// Bench for fp_multi_ch_accumulator: two lockstep instances (ReLU off / on), vector table plus
// scoreboard, with hand sequences for gaps, backpressure, async reset and back-to-back start.
module tb_fp_multi_ch_accumulator;

    typedef struct packed {
        logic [31:0]       b0, b1;
        logic [3:0][31:0]  d0, d1;
        logic [31:0]       e0, e1;
    } vec_t;

    typedef struct packed {
        logic [31:0] e0, e1;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, start, in_valid, out_ready;
    logic [63:0] bias_in, in_data;
    logic        in_ready0, out_valid0, busy0;
    logic        in_ready1, out_valid1, busy1;
    logic [63:0] out_data0, out_data1;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[7];
    exp_t sb[$];

    always #5 clk = ~clk;

    fp_multi_ch_accumulator #(.Num_Ch(2), .Acc_Len(4), .Relu_En(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .bias_in(bias_in),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .busy(busy0)
    );

    fp_multi_ch_accumulator #(.Num_Ch(2), .Acc_Len(4), .Relu_En(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .bias_in(bias_in),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .busy(busy1)
    );

    function automatic logic [31:0] relu_m(input logic [31:0] x);
        return x[31] ? 32'h0 : x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_ctl(input string name, input logic rdy, input logic vld, input logic bsy);
        chk(name, 64'({in_ready0, out_valid0, busy0, in_ready1, out_valid1, busy1}),
                  64'({rdy, vld, bsy, rdy, vld, bsy}));
    endtask

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic start_vec(input vec_t v);
        start   = 1'b1;
        bias_in = {v.b1, v.b0};
        cycle();
        start   = 1'b0;
        bias_in = {$urandom, $urandom};
    endtask

    task automatic beats(input vec_t v, input int unsigned maxgap);
        int unsigned gap;
        for (int i = 0; i < 4; i++) begin
            gap = $urandom_range(maxgap, 0);
            repeat (gap) begin
                in_valid = 1'b0;
                in_data  = {$urandom, $urandom};
                cycle();
                chk_ctl("gap_ctl", 1'b1, 1'b0, 1'b1);
            end
            in_valid = 1'b1;
            in_data  = {v.d1[i], v.d0[i]};
            chk_ctl("beat_ctl", 1'b1, 1'b0, 1'b1);
            if (i == 3) sb.push_back('{e0: v.e0, e1: v.e1});
            cycle();
        end
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid0 && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got out_valid with empty queue expected no output");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data_norelu", out_data0, {e.e1, e.e0});
                chk("out_data_relu", out_data1, {relu_m(e.e1), relu_m(e.e0)});
            end
        end
    end

    initial begin
        vecs[0] = '{b0: 32'h3F800000, b1: 32'hBF800000,
                    d0: {4{32'h3F000000}}, d1: {4{32'h3F000000}},
                    e0: 32'h40400000, e1: 32'h3F800000};
        vecs[1] = '{b0: 32'hBF800000, b1: 32'h40000000,
                    d0: {4{32'h00000000}}, d1: {4{32'h00000000}},
                    e0: 32'hBF800000, e1: 32'h40000000};
        vecs[2] = '{b0: 32'h80000000, b1: 32'h40000000,
                    d0: {4{32'h80000000}}, d1: {4{32'h3F800000}},
                    e0: 32'h80000000, e1: 32'h40C00000};
        vecs[3] = '{b0: 32'h41200000, b1: 32'h3F800000,
                    d0: {32'h3F400000, 32'hC1000000, 32'h3E800000, 32'hC0200000},
                    d1: {32'h3E000000, 32'hC0400000, 32'h3FC00000, 32'hBF800000},
                    e0: 32'h3F000000, e1: 32'hBFB00000};
        vecs[4] = '{b0: 32'h3F800000, b1: 32'h4B000001,
                    d0: {32'h0, 32'h0, 32'h0, 32'hBF800000}, d1: {4{32'h3F000000}},
                    e0: 32'h00000000, e1: 32'h4B000002};
        vecs[5] = '{b0: 32'hFF800000, b1: 32'h00000001,
                    d0: {4{32'h3F800000}}, d1: {4{32'h00000001}},
                    e0: 32'hFF800000, e1: 32'h00000005};
        vecs[6] = '{b0: 32'h40000000, b1: 32'hC0000000,
                    d0: {4{32'h3F800000}}, d1: {4{32'h3F800000}},
                    e0: 32'h40C00000, e1: 32'h40000000};

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        bias_in = '0; in_data = '0;
        cycle();
        cycle();
        chk_ctl("reset_ctl", 1'b0, 1'b0, 1'b0);
        chk("reset_data", out_data0 | out_data1, 64'h0);
        reset = 1'b0;
        cycle();

        // table vectors, odd entries with random in_valid gaps
        for (int v = 0; v < 6; v++) begin
            start_vec(vecs[v]);
            chk_ctl("start_lat", 1'b1, 1'b0, 1'b1);
            beats(vecs[v], (v % 2 == 1) ? 3 : 0);
            chk_ctl("done_lat", 1'b0, 1'b1, 1'b1);
            cycle();
            chk_ctl("back_idle", 1'b0, 1'b0, 1'b0);
        end

        // gaps between beats on the first vector
        start_vec(vecs[0]);
        beats(vecs[0], 3);
        chk_ctl("gap_done_lat", 1'b0, 1'b1, 1'b1);
        cycle();
        chk_ctl("gap_idle", 1'b0, 1'b0, 1'b0);

        // backpressure in OUT with stray in_valid/start
        out_ready = 1'b0;
        start_vec(vecs[3]);
        beats(vecs[3], 0);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom};
            start    = k[0];
            bias_in  = {$urandom, $urandom};
            chk_ctl("bp_ctl", 1'b0, 1'b1, 1'b1);
            chk("bp_data_norelu", out_data0, {32'hBFB00000, 32'h3F000000});
            chk("bp_data_relu", out_data1, {32'h00000000, 32'h3F000000});
            cycle();
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk_ctl("bp_hold", 1'b0, 1'b1, 1'b1);
        out_ready = 1'b1;
        cycle();
        chk_ctl("bp_release", 1'b0, 1'b0, 1'b0);
        chk("bp_keep_data", out_data0, {32'hBFB00000, 32'h3F000000});

        // asynchronous reset after two accepted beats
        start_vec(vecs[0]);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = {vecs[0].d1[i], vecs[0].d0[i]};
            cycle();
        end
        in_valid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk_ctl("rst_async_ctl", 1'b0, 1'b0, 1'b0);
        chk("rst_async_data", out_data0 | out_data1, 64'h0);
        cycle();
        reset = 1'b0;
        cycle();
        start_vec(vecs[0]);
        beats(vecs[0], 0);
        chk_ctl("rst_rerun_lat", 1'b0, 1'b1, 1'b1);
        cycle();

        // back-to-back: start on the output handshake
        start_vec(vecs[0]);
        beats(vecs[0], 0);
        chk_ctl("b2b_out", 1'b0, 1'b1, 1'b1);
        start   = 1'b1;
        bias_in = {vecs[6].b1, vecs[6].b0};
        cycle();
        start   = 1'b0;
        chk_ctl("b2b_accum", 1'b1, 1'b0, 1'b1);
        beats(vecs[6], 0);
        chk_ctl("b2b_done", 1'b0, 1'b1, 1'b1);
        cycle();
        chk_ctl("b2b_idle", 1'b0, 1'b0, 1'b0);

        cycle();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending results expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
